shift_reg_univ: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal shift register.
- Supports hold, shift, rotate, parallel load and clear modes.
- Has a self-timed "burst" serialiser that loads a word and streams it out LSB-first with busy/done handshake.
- Used as the general storage/serialisation element in sequential datapaths and as a serial-link front end.

---
 rtl/shift_reg_pkg.sv | 21 ++
 rtl/shift_reg_univ_burst_ctrl.sv | 79 +++++++
 rtl/shift_reg_univ.sv | 86 ++++++++
 tb/tb_shift_reg_univ.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register and its burst controller.
//   mode_e  : manual operation select (3 bits; 3'b111 is reserved and holds)
//   state_e : burst FSM states
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_CLR  = 3'b110
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/shift_reg_univ_burst_ctrl.sv
// Burst serialiser controller.
// Owns the IDLE/SHIFT FSM, the bit counter, busy and done, and tells the
// register datapath when to load the burst word and when to shift it.
//   clk       in   system clock
//   reset     in   synchronous active-high reset (aborts a burst, no done)
//   start     in   burst request, honoured only in IDLE
//   busy      out  high while a burst is in progress (WIDTH cycles)
//   done      out  registered one-cycle pulse after the final burst cycle
//   load_stb  out  datapath must load the parallel word this edge
//   shift_stb out  datapath must shift right (ser_in_r at MSB) this edge
module burst_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load_stb,
    output logic shift_stb
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. The load edge counts as burst cycle 0, so WIDTH-1
    // shifts follow it and the edge where cnt reaches WIDTH-1 only retires
    // the burst; that is what keeps busy high for exactly WIDTH cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q == ST_SHIFT);
        load_stb  = (state_q == ST_IDLE) && start;
        shift_stb = (state_q == ST_SHIFT) && (cnt_q != CNT_LAST);
        done      = done_q;
    end

endmodule

// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal shift register with a self-timed LSB-first burst
// serialiser.
//   clk        in   system clock
//   reset      in   synchronous active-high reset, q <= RESET_VAL
//   en         in   enables manual modes (ignored while busy or on start)
//   mode       in   manual op: hold/shr/shl/ror/rol/load/clr (111 = hold)
//   d          in   parallel data for load and burst start
//   ser_in_r   in   bit entering at MSB on right shift and during a burst
//   ser_in_l   in   bit entering at LSB on left shift
//   start      in   burst request, acted on only when idle
//   q          out  register contents
//   ser_out_r  out  q[0]
//   ser_out_l  out  q[WIDTH-1]
//   busy       out  burst in progress
//   done       out  one-cycle pulse at burst completion
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             load_stb;
    logic             shift_stb;

    burst_ctrl #(
        .WIDTH (WIDTH)
    ) u_burst_ctrl (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .load_stb  (load_stb),
        .shift_stb (shift_stb)
    );

    // Burst strobes win over manual modes; manual ops only when idle and
    // no burst is being requested.
    always_comb begin
        q_d = q_q;
        if (load_stb) begin
            q_d = d;
        end else if (shift_stb) begin
            q_d = {ser_in_r, q_q[WIDTH-1:1]};
        end else if (en && !busy && !start) begin
            case (mode)
                MODE_SHR:  q_d = {ser_in_r, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], ser_in_l};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_LOAD: q_d = d;
                MODE_CLR:  q_d = '0;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign ser_out_r = q_q[0];
    assign ser_out_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         reset, en, ser_in_r, ser_in_l, start;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         ser_out_r, ser_out_l, busy, done;

    int checks = 0;
    int errors = 0;

    shift_reg_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .start     (start),
        .q         (q),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: a burst is tracked by its age in cycles since the
    // load edge; it is busy for ages 0..W-1 and signals done as it expires.
    logic [W-1:0] m_q;
    int           m_age   = -1;
    bit           m_done  = 1'b0;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q = RV; m_age = -1; m_done = 1'b0; m_valid = 1'b1;
        end else if (m_age >= 0) begin
            if (m_age < W - 1) m_q = (m_q >> 1) | (W'(ser_in_r) << (W - 1));
            m_age++;
            m_done = (m_age == W);
            if (m_done) m_age = -1;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_q = d; m_age = 0;
            end else if (en) begin
                case (mode)
                    3'd1: m_q = (m_q >> 1) | (W'(ser_in_r) << (W - 1));
                    3'd2: m_q = (m_q << 1) | W'(ser_in_l);
                    3'd3: m_q = (m_q >> 1) | (W'(m_q[0]) << (W - 1));
                    3'd4: m_q = (m_q << 1) | W'(m_q[W-1]);
                    3'd5: m_q = d;
                    3'd6: m_q = '0;
                    default: ;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (q !== m_q || ser_out_r !== m_q[0] || ser_out_l !== m_q[W-1] ||
                busy !== (m_age >= 0) || done !== m_done) begin
                errors++;
                $display("FAIL model t=%0t actual q=%h sr=%b sl=%b busy=%b done=%b required q=%h busy=%b done=%b",
                         $time, q, ser_out_r, ser_out_l, busy, done, m_q, (m_age >= 0), m_done);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Run one full burst starting now (start already set by caller for this
    // edge), checking ser_out_r bit by bit. pulse_at >= 0 re-asserts start
    // during that burst cycle, which must be ignored.
    task automatic burst_check(input logic [W-1:0] word, input int pulse_at);
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk("burst_bit", 32'(ser_out_r), 32'(word[i]));
            chk("burst_busy", 32'(busy), 32'd1);
            chk("burst_nodone", 32'(done), 32'd0);
            start = (i == pulse_at);
            tick();
            start = 1'b0;
        end
        chk("burst_done", 32'(done), 32'd1);
        chk("burst_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 3'b101; d = 8'hFF;
        ser_in_r = 1'b0; ser_in_l = 1'b0; start = 1'b0;

        // Reset held three cycles with a load requested
        repeat (3) begin
            tick();
            chk("rst_q", 32'(q), 32'hA5);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end
        reset = 1'b0; en = 1'b0;
        tick(); chk("en0_hold", 32'(q), 32'hA5);

        // Manual modes
        en = 1'b1;
        mode = 3'b101; d = 8'h81;     tick(); chk("load", 32'(q), 32'h81);
        mode = 3'b001; ser_in_r = 1;  tick(); chk("shr",  32'(q), 32'hC0);
        mode = 3'b010; ser_in_l = 0;  tick(); chk("shl",  32'(q), 32'h80);
        mode = 3'b011;                tick(); chk("ror",  32'(q), 32'h40);
        mode = 3'b100;                tick(); chk("rol",  32'(q), 32'h80);
        mode = 3'b110;                tick(); chk("clr",  32'(q), 32'h00);
        mode = 3'b111;                tick(); chk("rsvd", 32'(q), 32'h00);

        // Plain burst of B4
        en = 1'b0; ser_in_r = 1'b0; d = 8'hB4; start = 1'b1;
        burst_check(8'hB4, -1);
        chk("burst_final_q", 32'(q), 32'h01);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("q_holds", 32'(q), 32'h01);

        // Burst with start pulse at cycle 3 and clear mode throughout
        en = 1'b1; mode = 3'b110; d = 8'hB4; start = 1'b1;
        burst_check(8'hB4, 2);
        chk("mid_final_q", 32'(q), 32'h01);
        // Back-to-back start on the done cycle
        d = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_bit0", 32'(ser_out_r), 32'd1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_nodone", 32'(done), 32'd0);

        // Reset during burst cycle 4
        en = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_q", 32'(q), 32'hA5);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (W + 2) begin
            tick();
            chk("abort_nodone", 32'(done), 32'd0);
        end

        d = 8'h3C; start = 1'b1;
        burst_check(8'h3C, -1);
        chk("post_abort_q", 32'(q), 32'h00);

        // Randomized phase, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 149) == 0);
            en       = ($urandom_range(0, 3) != 0);
            mode     = 3'($urandom_range(0, 7));
            d        = W'($urandom);
            ser_in_r = 1'($urandom);
            ser_in_l = 1'($urandom);
            start    = ($urandom_range(0, 5) == 0);
            tick();
        end
        reset = 1'b0; start = 1'b0; en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
